sha256_round_sequencer: RTL and testbench
=========================================

Name: sha256_round_sequencer

Overview:
Control FSM that drives one MOD_COMPRESSOR instance through a full SHA-256 block: H-bin load, 64 rounds, then final digest readback.
- Supplies HI, WI, H_IN and K_IN; K_IN comes from an internal constant ROM.
- Stalls rounds on the message-schedule W_VALID handshake.
- Keeps chaining registers so consecutive 512-bit blocks hash back-to-back.
- Sits between the top-level hash controller and the compressor/message-schedule pair.

Parameters:
ROUNDS, 64, rounds per block; WI width fixed at 6 bits.
HBINS, 8, number of H words; HI width fixed at 3 bits.

Ports:
CLK  in  1  system clock, rising edge
RST_N  in  1  asynchronous active-low reset
START  in  1  begin a block; sampled only in IDLE
FIRST_BLOCK  in  1  latched with START: 1 = load IV constants, 0 = load chaining regs
W_VALID  in  1  message schedule has W[WI] ready this cycle
H_OUT  in  32  compressor result word for current HI (combinational)
HI  out  3  H-bin index to compressor
WI  out  6  round index to compressor and message schedule
H_IN  out  32  H word for HI during LOAD
K_IN  out  32  K[WI] during ROUND, else 0
PHASE  out  2  00 IDLE, 01 LOAD, 10 ROUND, 11 FINAL
ROUND_EN  out  1  compressor executes round WI this cycle
BUSY  out  1  high in every state except IDLE
DONE  out  1  one-cycle pulse after FINAL
DIGEST_VALID  out  1  DIGEST_WORD valid this cycle
DIGEST_IDX  out  3  index of DIGEST_WORD
DIGEST_WORD  out  32  final H word

Behaviour:
Reset (RST_N low, async):
- State IDLE.
- HI=0, WI=0, PHASE=00.
- ROUND_EN, BUSY, DONE, DIGEST_VALID = 0; DIGEST_IDX=0, DIGEST_WORD=0, K_IN=0.
- Chaining regs CHAIN[0..7] = IV constants; first_lat = 1.
- Reset mid-block abandons the block; no DONE is issued.

States:
- IDLE: START=1 latches FIRST_BLOCK and goes to LOAD with HI=0. START=0 stays in IDLE.
- LOAD: 8 cycles, HI=0..7.
  - H_IN = first_lat ? IV[HI] : CHAIN[HI] (combinational from HI).
  - After HI=7: go to ROUND with WI=0.
- ROUND:
  - ROUND_EN = W_VALID; K_IN = K[WI].
  - W_VALID=1 advances WI by 1. W_VALID=0 holds WI with ROUND_EN=0 (stall, no limit).
  - WI=63 with W_VALID=1: go to FINAL with HI=0. WI wraps to 0.
- FINAL: 8 cycles, HI=0..7.
  - DIGEST_VALID=1, DIGEST_IDX=HI, DIGEST_WORD=H_OUT (registered, appears one cycle after HI is driven).
  - CHAIN[HI] <= H_OUT each cycle.
  - After HI=7: go to DONE.
- DONE: DONE=1 for one cycle, then IDLE.
  - START asserted during DONE is ignored; START is accepted again from IDLE.

Timing and edge cases:
- Unstalled latency, START edge to DONE: 1 + 8 + 64 + 8 + 1 = 82 cycles. DONE high in cycle 82.
- DIGEST_VALID high for 8 cycles, beats 74..81, ending coincident with DONE's preceding cycle.
- START while BUSY: ignored, no queuing.
- W_VALID outside ROUND: ignored.
- HI/WI are never out of range. All index arithmetic is modulo its field width.
- FIRST_BLOCK=0 on the very first block after reset loads CHAIN = IV, which is legal and gives the same result as FIRST_BLOCK=1.

Decomposition:
- Package sha256_pkg:
  - K[0..63] constant array and IV[0..7] constant array.
  - State enum {IDLE, LOAD, ROUND, FINAL, DONE} and PHASE encodings.
  - Localparams WORD_W=32, HI_W=3, WI_W=6.
- Sub-module sha256_k_rom: combinational WI -> K lookup, shared later with any unrolled datapath.
- FSM, counters and chaining registers stay in sha256_round_sequencer.

Test Plan:
- Reset check: RST_N low mid-ROUND at WI=20 -> next cycle state IDLE, WI=0, BUSY=0, no DONE; after release, CHAIN equals IV (0x6a09e667 .. 0x5be0cd19).
- Single block, real MOD_COMPRESSOR, W = padded "Hello world!", W_VALID=1 constant, FIRST_BLOCK=1:
  - DONE at cycle 82 after START.
  - H_IN sequence during LOAD is 0x6a09e667, 0xbb67ae85 .. 0x5be0cd19.
  - K_IN=0x428a2f98 at WI=0 and 0xc67178f2 at WI=63.
  - Digest words 0xc0535e4b, 0xe2b79ffd, 0x93291305, 0x436bf889, 0x314e4a3f, 0xaec05ecf, 0xfcbb7df3, 0x1ad9e51a.
- Stall: W_VALID=0 for 5 cycles at WI=10 -> WI holds at 10, ROUND_EN=0 for those 5 cycles, DONE at cycle 87.
- Chaining: stub H_OUT = 0x1000_0000 + HI, then second block with FIRST_BLOCK=0 -> LOAD H_IN sequence is 0x10000000 .. 0x10000007.
- START pulsed while BUSY (in LOAD, ROUND and DONE) -> no restart, cycle count unchanged, exactly one DONE pulse per accepted START.

Source files
------------

// File: rtl/sha256_pkg.sv
// Shared SHA-256 sequencing definitions.
// Holds the round-constant and initial-hash tables, the sequencer state
// encoding, the PHASE output encodings and the field widths used by the
// round sequencer and the K-constant ROM. No ports.
package sha256_pkg;

  localparam int WORD_W = 32;
  localparam int HI_W   = 3;
  localparam int WI_W   = 6;
  localparam int ROUNDS = 64;
  localparam int HBINS  = 8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_ROUND = 3'd2,
    ST_FINAL = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  localparam logic [1:0] PH_IDLE  = 2'b00;
  localparam logic [1:0] PH_LOAD  = 2'b01;
  localparam logic [1:0] PH_ROUND = 2'b10;
  localparam logic [1:0] PH_FINAL = 2'b11;

  localparam logic [WORD_W-1:0] K_TABLE [ROUNDS] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  localparam logic [WORD_W-1:0] IV_TABLE [HBINS] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

endpackage

// File: rtl/sha256_k_rom.sv
// Combinational SHA-256 round-constant lookup.
// Ports:
//   wi_i : round index 0..63
//   k_o  : K[wi_i]
module sha256_k_rom
  import sha256_pkg::*;
(
  input  logic [WI_W-1:0]   wi_i,
  output logic [WORD_W-1:0] k_o
);

  // Pure table lookup; the index field covers the table exactly.
  always_comb begin
    k_o = K_TABLE[wi_i];
  end

endmodule

// File: rtl/sha256_round_sequencer.sv
// Control sequencer driving one SHA-256 compressor through a block:
// 8-cycle H load, 64 W_VALID-gated rounds, 8-cycle digest readback,
// then a one-cycle DONE pulse. Chaining registers keep the last digest
// so the next block can continue the hash without host reload.
// Ports:
//   clk_i, rst_n_i           : clock (rising edge), async active-low reset
//   start_i, first_block_i   : block request, IV-vs-chain select (sampled in IDLE)
//   w_valid_i                : message schedule word ready
//   h_out_i                  : compressor result for current hi_o
//   hi_o, wi_o               : H-bin / round index to the datapath
//   h_in_o, k_in_o           : H word during LOAD, K[wi_o] during ROUND
//   phase_o, round_en_o      : phase code, round execute strobe
//   busy_o, done_o           : activity flag, completion pulse
//   digest_valid_o/idx_o/word_o : registered digest readback stream
module sha256_round_sequencer
  import sha256_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              start_i,
  input  logic              first_block_i,
  input  logic              w_valid_i,
  input  logic [WORD_W-1:0] h_out_i,
  output logic [HI_W-1:0]   hi_o,
  output logic [WI_W-1:0]   wi_o,
  output logic [WORD_W-1:0] h_in_o,
  output logic [WORD_W-1:0] k_in_o,
  output logic [1:0]        phase_o,
  output logic              round_en_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              digest_valid_o,
  output logic [HI_W-1:0]   digest_idx_o,
  output logic [WORD_W-1:0] digest_word_o
);

  localparam logic [HI_W-1:0] HI_LAST = HI_W'(HBINS - 1);
  localparam logic [WI_W-1:0] WI_LAST = WI_W'(ROUNDS - 1);

  state_e              state_q, state_d;
  logic [HI_W-1:0]     hi_q, hi_d;
  logic [WI_W-1:0]     wi_q, wi_d;
  logic                first_q, first_d;
  logic [WORD_W-1:0]   chain_q [HBINS];
  logic                digest_valid_q;
  logic [HI_W-1:0]     digest_idx_q;
  logic [WORD_W-1:0]   digest_word_q;
  logic                done_q;
  logic [WORD_W-1:0]   k_rom_s;

  sha256_k_rom u_k_rom (
    .wi_i (wi_q),
    .k_o  (k_rom_s)
  );

  // Next-state and index counter logic.
  always_comb begin
    state_d = state_q;
    hi_d    = hi_q;
    wi_d    = wi_q;
    first_d = first_q;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          first_d = first_block_i;
          hi_d    = 3'd0;
          state_d = ST_LOAD;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LOAD: begin
        hi_d = hi_q + 3'd1;
        if (hi_q == HI_LAST) begin
          wi_d    = 6'd0;
          state_d = ST_ROUND;
        end else begin
          state_d = ST_LOAD;
        end
      end
      ST_ROUND: begin
        // A missing W word simply freezes the round index.
        if (w_valid_i) begin
          wi_d = wi_q + 6'd1;
          if (wi_q == WI_LAST) begin
            hi_d    = 3'd0;
            state_d = ST_FINAL;
          end else begin
            state_d = ST_ROUND;
          end
        end else begin
          wi_d = wi_q;
        end
      end
      ST_FINAL: begin
        hi_d = hi_q + 3'd1;
        if (hi_q == HI_LAST) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_FINAL;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, counters and block-select latch.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= ST_IDLE;
      hi_q    <= 3'd0;
      wi_q    <= 6'd0;
      first_q <= 1'b1;
    end else begin
      state_q <= state_d;
      hi_q    <= hi_d;
      wi_q    <= wi_d;
      first_q <= first_d;
    end
  end

  // Chaining registers capture each digest word as it is read back.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < HBINS; i++) begin
        chain_q[i] <= IV_TABLE[i];
      end
    end else if (state_q == ST_FINAL) begin
      chain_q[hi_q] <= h_out_i;
    end
  end

  // Digest stream lags hi by one cycle; DONE follows the drain cycle so it
  // lands right after the last digest beat.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      digest_valid_q <= 1'b0;
      digest_idx_q   <= 3'd0;
      digest_word_q  <= 32'd0;
      done_q         <= 1'b0;
    end else begin
      digest_valid_q <= (state_q == ST_FINAL);
      done_q         <= (state_q == ST_DONE);
      if (state_q == ST_FINAL) begin
        digest_idx_q  <= hi_q;
        digest_word_q <= h_out_i;
      end
    end
  end

  // Output decode from registered state.
  always_comb begin
    phase_o = PH_IDLE;
    case (state_q)
      ST_IDLE:  phase_o = PH_IDLE;
      ST_LOAD:  phase_o = PH_LOAD;
      ST_ROUND: phase_o = PH_ROUND;
      ST_FINAL: phase_o = PH_FINAL;
      ST_DONE:  phase_o = PH_FINAL;
      default:  phase_o = PH_IDLE;
    endcase
  end

  assign hi_o           = hi_q;
  assign wi_o           = wi_q;
  assign h_in_o         = first_q ? IV_TABLE[hi_q] : chain_q[hi_q];
  assign k_in_o         = (state_q == ST_ROUND) ? k_rom_s : 32'd0;
  assign round_en_o     = (state_q == ST_ROUND) && w_valid_i;
  assign busy_o         = (state_q != ST_IDLE);
  assign done_o         = done_q;
  assign digest_valid_o = digest_valid_q;
  assign digest_idx_o   = digest_idx_q;
  assign digest_word_o  = digest_word_q;

endmodule

// File: tb/tb_sha256_round_sequencer.sv
// Directed bench for sha256_round_sequencer. A behavioural SHA-256
// compressor (or a fixed-pattern stub) answers H_OUT; expected values are
// hand-known constants (IV, K, digest of "Hello world!").
module tb_sha256_round_sequencer;

  localparam logic [31:0] IV_EXP [8] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };
  localparam logic [31:0] HELLO_EXP [8] = '{
    32'hc0535e4b, 32'he2b79ffd, 32'h93291305, 32'h436bf889,
    32'h314e4a3f, 32'haec05ecf, 32'hfcbb7df3, 32'h1ad9e51a
  };

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, first_block, w_valid;
  logic [31:0] h_out;
  logic [2:0]  hi;
  logic [5:0]  wi;
  logic [31:0] h_in, k_in;
  logic [1:0]  phase;
  logic        round_en, busy, done, digest_valid;
  logic [2:0]  digest_idx;
  logic [31:0] digest_word;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  sha256_round_sequencer dut (
    .clk_i          (clk),
    .rst_n_i        (rst_n),
    .start_i        (start),
    .first_block_i  (first_block),
    .w_valid_i      (w_valid),
    .h_out_i        (h_out),
    .hi_o           (hi),
    .wi_o           (wi),
    .h_in_o         (h_in),
    .k_in_o         (k_in),
    .phase_o        (phase),
    .round_en_o     (round_en),
    .busy_o         (busy),
    .done_o         (done),
    .digest_valid_o (digest_valid),
    .digest_idx_o   (digest_idx),
    .digest_word_o  (digest_word)
  );

  // ---------------- compressor model ----------------
  logic [31:0] hreg [8];
  logic [31:0] v    [8];
  logic [31:0] wsch [64];
  bit          stub_mode = 1'b0;

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  assign h_out = stub_mode ? (32'h1000_0000 + {29'd0, hi}) : (hreg[hi] + v[hi]);

  always @(posedge clk) begin : comp_model
    logic [31:0] t1, t2;
    if (phase == 2'b01) begin
      hreg[hi] <= h_in;
      v[hi]    <= h_in;
    end else if (round_en) begin
      t1 = v[7] + (rotr(v[4], 6) ^ rotr(v[4], 11) ^ rotr(v[4], 25))
           + ((v[4] & v[5]) ^ (~v[4] & v[6])) + k_in + wsch[wi];
      t2 = (rotr(v[0], 2) ^ rotr(v[0], 13) ^ rotr(v[0], 22))
           + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
      v[7] <= v[6]; v[6] <= v[5]; v[5] <= v[4]; v[4] <= v[3] + t1;
      v[3] <= v[2]; v[2] <= v[1]; v[1] <= v[0]; v[0] <= t1 + t2;
    end
  end

  // ---------------- block driver / observation logs ----------------
  logic [31:0] hin_log [8];
  logic [31:0] dig_log [8];
  logic [31:0] k0, k63;
  int n_hin, n_dig, dig_first, dig_last, done_cnt, done_cyc, stall_seen, kbad, load_first;

  task automatic drive_block(input logic first, input int stall_len, input bit poke);
    int cyc;
    int stall_left;
    bit fin;
    for (int i = 0; i < 8; i++) begin
      hin_log[i] = 32'hxxxxxxxx;
      dig_log[i] = 32'hxxxxxxxx;
    end
    n_hin = 0; n_dig = 0; dig_first = -1; dig_last = -1; done_cnt = 0;
    done_cyc = -1; stall_seen = 0; kbad = 0; load_first = -1;
    k0 = 32'd0; k63 = 32'd0;
    @(negedge clk);
    start = 1'b1; first_block = first; w_valid = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 1; stall_left = stall_len; fin = 1'b0;
    while (!fin && cyc < 300) begin
      w_valid = 1'b1;
      if (phase == 2'b10 && wi == 6'd10 && stall_left > 0) begin
        w_valid = 1'b0;
        stall_left--;
      end
      start = poke && (cyc == 3 || cyc == 40 || cyc == 81);
      #1;
      if (phase == 2'b01 && n_hin < 8) begin
        if (n_hin == 0) load_first = cyc;
        hin_log[n_hin] = h_in;
        n_hin++;
      end
      if (phase == 2'b10 && round_en && wi == 6'd0)  k0  = k_in;
      if (phase == 2'b10 && round_en && wi == 6'd63) k63 = k_in;
      if (phase == 2'b10 && !round_en && wi == 6'd10) stall_seen++;
      if (phase != 2'b10 && k_in !== 32'd0) kbad++;
      if (digest_valid) begin
        dig_log[digest_idx] = digest_word;
        if (dig_first < 0) dig_first = cyc;
        dig_last = cyc;
        n_dig++;
      end
      if (done) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = cyc;
      end
      if (done_cyc >= 0 && cyc >= done_cyc + 4) fin = 1'b1;
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; first_block = 1'b0; w_valid = 1'b0;
    repeat (2) @(negedge clk);
    n_vec++;
    if ({phase, hi, wi, round_en, busy, done, digest_valid, digest_idx} !== 17'd0) begin
      n_err++;
      $display("FAIL reset_ctrl: got ph=%b hi=%0d wi=%0d re=%b busy=%b done=%b dv=%b di=%0d want all zero",
               phase, hi, wi, round_en, busy, done, digest_valid, digest_idx);
    end
    n_vec++;
    if (digest_word !== 32'd0 || k_in !== 32'd0) begin
      n_err++;
      $display("FAIL reset_data: got dw=%h k=%h want 0/0", digest_word, k_in);
    end
    n_vec++;
    if (h_in !== IV_EXP[0]) begin
      n_err++;
      $display("FAIL reset_hin: got %h want %h", h_in, IV_EXP[0]);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single_block();
    stub_mode = 1'b0;
    drive_block(1'b1, 0, 1'b0);
    n_vec++;
    if (done_cyc !== 82) begin n_err++; $display("FAIL hello_done_cycle: got %0d want 82", done_cyc); end
    n_vec++;
    if (done_cnt !== 1) begin n_err++; $display("FAIL hello_done_count: got %0d want 1", done_cnt); end
    n_vec++;
    if (load_first !== 1) begin n_err++; $display("FAIL hello_load_cycle: got %0d want 1", load_first); end
    for (int i = 0; i < 8; i++) begin
      n_vec++;
      if (hin_log[i] !== IV_EXP[i]) begin
        n_err++; $display("FAIL hello_hin[%0d]: got %h want %h", i, hin_log[i], IV_EXP[i]);
      end
    end
    n_vec++;
    if (k0 !== 32'h428a2f98) begin n_err++; $display("FAIL k_wi0: got %h want 428a2f98", k0); end
    n_vec++;
    if (k63 !== 32'hc67178f2) begin n_err++; $display("FAIL k_wi63: got %h want c67178f2", k63); end
    n_vec++;
    if (kbad !== 0) begin n_err++; $display("FAIL k_outside_round: got %0d nonzero cycles want 0", kbad); end
    n_vec++;
    if (dig_first !== 74 || dig_last !== 81 || n_dig !== 8) begin
      n_err++;
      $display("FAIL hello_digest_window: got %0d..%0d (%0d beats) want 74..81 (8)", dig_first, dig_last, n_dig);
    end
    for (int i = 0; i < 8; i++) begin
      n_vec++;
      if (dig_log[i] !== HELLO_EXP[i]) begin
        n_err++; $display("FAIL hello_digest[%0d]: got %h want %h", i, dig_log[i], HELLO_EXP[i]);
      end
    end
  endtask

  task automatic test_chaining();
    stub_mode = 1'b1;
    drive_block(1'b0, 0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      n_vec++;
      if (hin_log[i] !== HELLO_EXP[i]) begin
        n_err++; $display("FAIL chain1_hin[%0d]: got %h want %h", i, hin_log[i], HELLO_EXP[i]);
      end
    end
    drive_block(1'b0, 0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      n_vec++;
      if (hin_log[i] !== 32'h1000_0000 + i) begin
        n_err++; $display("FAIL chain2_hin[%0d]: got %h want %h", i, hin_log[i], 32'h1000_0000 + i);
      end
    end
    n_vec++;
    if (done_cyc !== 82) begin n_err++; $display("FAIL chain2_done_cycle: got %0d want 82", done_cyc); end
  endtask

  task automatic test_stall();
    stub_mode = 1'b0;
    drive_block(1'b1, 5, 1'b0);
    n_vec++;
    if (done_cyc !== 87) begin n_err++; $display("FAIL stall_done_cycle: got %0d want 87", done_cyc); end
    n_vec++;
    if (stall_seen !== 5) begin n_err++; $display("FAIL stall_hold: got %0d held cycles want 5", stall_seen); end
    n_vec++;
    if (hin_log[0] !== IV_EXP[0] || hin_log[7] !== IV_EXP[7]) begin
      n_err++; $display("FAIL stall_iv_reload: got %h/%h want %h/%h", hin_log[0], hin_log[7], IV_EXP[0], IV_EXP[7]);
    end
    for (int i = 0; i < 8; i++) begin
      n_vec++;
      if (dig_log[i] !== HELLO_EXP[i]) begin
        n_err++; $display("FAIL stall_digest[%0d]: got %h want %h", i, dig_log[i], HELLO_EXP[i]);
      end
    end
  endtask

  task automatic test_busy_start();
    stub_mode = 1'b1;
    drive_block(1'b1, 0, 1'b1);
    n_vec++;
    if (done_cyc !== 82) begin n_err++; $display("FAIL busy_start_done_cycle: got %0d want 82", done_cyc); end
    n_vec++;
    if (done_cnt !== 1) begin n_err++; $display("FAIL busy_start_done_count: got %0d want 1", done_cnt); end
    n_vec++;
    if (busy !== 1'b0) begin n_err++; $display("FAIL busy_start_restart: got busy=%b want 0", busy); end
  endtask

  task automatic test_mid_reset();
    int guard;
    bit seen_done;
    stub_mode = 1'b1;
    @(negedge clk);
    start = 1'b1; first_block = 1'b1; w_valid = 1'b1;
    @(negedge clk);
    start = 1'b0;
    guard = 0;
    while (!(phase == 2'b10 && wi == 6'd20) && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    n_vec++;
    if (guard >= 200) begin n_err++; $display("FAIL midrst_reach_wi20: got timeout want wi=20"); end
    rst_n = 1'b0;
    #1;
    n_vec++;
    if (phase !== 2'b00 || wi !== 6'd0 || busy !== 1'b0 || done !== 1'b0 || round_en !== 1'b0) begin
      n_err++;
      $display("FAIL midrst_state: got ph=%b wi=%0d busy=%b done=%b re=%b want 00/0/0/0/0",
               phase, wi, busy, done, round_en);
    end
    seen_done = 1'b0;
    repeat (2) begin
      @(negedge clk);
      if (done) seen_done = 1'b1;
    end
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (done) seen_done = 1'b1;
    end
    n_vec++;
    if (seen_done !== 1'b0) begin n_err++; $display("FAIL midrst_no_done: got done pulse want none"); end
    drive_block(1'b0, 0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      n_vec++;
      if (hin_log[i] !== IV_EXP[i]) begin
        n_err++; $display("FAIL midrst_chain_iv[%0d]: got %h want %h", i, hin_log[i], IV_EXP[i]);
      end
    end
  endtask

  initial begin
    // padded "Hello world!" block and its message schedule
    for (int t = 0; t < 16; t++) wsch[t] = 32'd0;
    wsch[0]  = 32'h48656c6c;
    wsch[1]  = 32'h6f20776f;
    wsch[2]  = 32'h726c6421;
    wsch[3]  = 32'h80000000;
    wsch[15] = 32'h00000060;
    for (int t = 16; t < 64; t++) begin
      wsch[t] = (rotr(wsch[t-2], 17) ^ rotr(wsch[t-2], 19) ^ (wsch[t-2] >> 10)) + wsch[t-7]
              + (rotr(wsch[t-15], 7) ^ rotr(wsch[t-15], 18) ^ (wsch[t-15] >> 3)) + wsch[t-16];
    end
    test_reset();
    test_single_block();
    test_chaining();
    test_stall();
    test_busy_start();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
